// File: rtl/ssd_counter_ctrl.sv
// Run/pause/clear/load controller for a 16-bit display counter, with a two-digit
// time-multiplexed PmodSSD driver that blanks the segment bus between digits.
module ssd_counter_ctrl #(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned TICK_HZ      = 100,
   parameter int unsigned REFRESH_HZ   = 1000,
   parameter int unsigned BLANK_CYCLES = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run_toggle,
   input  logic        clear,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        disp_sel,
   output logic [15:0] count,
   output logic        running,
   output logic        tick,
   output logic        wrap,
   output logic [6:0]  seg,
   output logic        dig_sel
);

   localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
   localparam int unsigned SLOT   = CLK_HZ / (2 * REFRESH_HZ);
   localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned SLOT_W = (SLOT > 1) ? $clog2(SLOT) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV - 1);
   localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
   localparam logic [SLOT_W-1:0] SHOW_LAST  = SLOT_W'(SLOT - BLANK_CYCLES - 1);

   typedef enum logic [1:0] {StBlankLo, StShowLo, StBlankHi, StShowHi} disp_state_e;

   logic [15:0]      count_q;
   logic [DIV_W-1:0] div_q;
   logic             running_q, tick_q, wrap_q;

   disp_state_e       state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [7:0]        disp_byte_q, disp_byte_d;
   logic [6:0]        seg_q, seg_d;
   logic              dig_q, dig_d;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      s = 7'b0000000;
      unique case (nib)
         4'h0: s = 7'b0111111;
         4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;
         4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;
         4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;
         4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b1111100;
         4'hC: s = 7'b0111001;
         4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;
         4'hF: s = 7'b1110001;
      endcase
      return s;
   endfunction

   // clear/load win over the increment and restart the tick period
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         div_q     <= '0;
         running_q <= 1'b0;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
         if (run_toggle) running_q <= ~running_q;
         if (clear) begin
            count_q <= '0;
            div_q   <= '0;
         end else if (load) begin
            count_q <= load_value;
            div_q   <= '0;
         end else if (running_q) begin
            if (div_q == DIV_LAST) begin
               div_q   <= '0;
               count_q <= count_q + 16'd1;
               tick_q  <= 1'b1;
               wrap_q  <= (count_q == 16'hFFFF);
            end else begin
               div_q <= div_q + DIV_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StBlankLo;
         slot_q      <= '0;
         disp_byte_q <= '0;
         seg_q       <= '0;
         dig_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         disp_byte_q <= disp_byte_d;
         seg_q       <= seg_d;
         dig_q       <= dig_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q + SLOT_W'(1);
      disp_byte_d = disp_byte_q;
      unique case (state_q)
         StBlankLo: if (slot_q == BLANK_LAST) state_d = StShowLo;
         StShowLo:  if (slot_q == SHOW_LAST)  state_d = StBlankHi;
         StBlankHi: if (slot_q == BLANK_LAST) state_d = StShowHi;
         StShowHi: begin
            if (slot_q == SHOW_LAST) begin
               state_d = StBlankLo;
               // latch once per frame so both digits show the same count
               disp_byte_d = disp_sel ? count_q[15:8] : count_q[7:0];
            end
         end
      endcase
      if (state_d != state_q) slot_d = '0;
      dig_d = (state_d == StBlankHi) || (state_d == StShowHi);
      seg_d = '0;
      if (state_d == StShowLo) seg_d = hex7(disp_byte_q[3:0]);
      if (state_d == StShowHi) seg_d = hex7(disp_byte_q[7:4]);
   end

   assign count   = count_q;
   assign running = running_q;
   assign tick    = tick_q;
   assign wrap    = wrap_q;
   assign seg     = seg_q;
   assign dig_sel = dig_q;

endmodule

// File: tb/tb_ssd_counter_ctrl.sv
// Directed bench for ssd_counter_ctrl: a control-priority vector table plus
// hand-written multi-cycle sequences for ticking, pause/resume, wrap and display.
module tb_ssd_counter_ctrl;

   localparam logic [6:0] SEG_0 = 7'b0111111;
   localparam logic [6:0] SEG_3 = 7'b1001111;
   localparam logic [6:0] SEG_7 = 7'b0000111;
   localparam logic [6:0] SEG_A = 7'b1110111;
   localparam logic [6:0] SEG_D = 7'b1011110;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run_toggle = 1'b0, clear = 1'b0, load = 1'b0, disp_sel = 1'b0;
   logic [15:0] load_value = '0;
   logic [15:0] count;
   logic        running, tick, wrap, dig_sel;
   logic [6:0]  seg;

   int n_vec = 0;
   int n_err = 0;
   int n = 0;  // edges since reset released; frame position is n % 20

   ssd_counter_ctrl #(
      .CLK_HZ(1000), .TICK_HZ(100), .REFRESH_HZ(50), .BLANK_CYCLES(2)
   ) dut (
      .clk(clk), .rst(rst), .run_toggle(run_toggle), .clear(clear), .load(load),
      .load_value(load_value), .disp_sel(disp_sel), .count(count), .running(running),
      .tick(tick), .wrap(wrap), .seg(seg), .dig_sel(dig_sel)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rt, cl, ld;
      logic [15:0] val;
      logic [15:0] exp_count;
      logic        exp_run;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      if (rst) n = 0;
      else n++;
   endtask

   task automatic pulse(input logic rt, input logic cl, input logic ld, input logic [15:0] val);
      run_toggle = rt; clear = cl; load = ld; load_value = val;
      step();
      run_toggle = 1'b0; clear = 1'b0; load = 1'b0;
   endtask

   task automatic sync_frame();
      int guard = 0;
      do begin
         step();
         guard++;
      end while ((n % 20) != 0 && guard < 40);
      check("frame_sync", 32'(guard <= 20), 32'd1);
   endtask

   task automatic check_display(input logic [6:0] lo, input logic [6:0] hi, input string tag);
      int p;
      logic [6:0] es;
      p  = n % 20;
      es = (p < 2 || (p >= 10 && p < 12)) ? 7'd0 : ((p < 10) ? lo : hi);
      check({tag, "_seg"}, 32'(seg), 32'(es));
      check({tag, "_dig"}, 32'(dig_sel), 32'(p >= 10));
   endtask

   task automatic check_frame(input logic [6:0] lo, input logic [6:0] hi, input string tag);
      for (int k = 0; k < 20; k++) begin
         check_display(lo, hi, tag);
         if (k < 19) step();
      end
   endtask

   initial begin
      // starts from count=0, paused
      tbl[0] = '{1'b0, 1'b0, 1'b1, 16'h1234, 16'h1234, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 16'hBEEF, 16'hBEEF, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 16'h00FF, 16'h00FF, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 16'h5555, 16'h00FF, 1'b1};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h5555, 16'h00FF, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};

      // 1: reset and idle
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      check("rst_count", 32'(count), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      check("rst_seg", 32'(seg), 32'd0);
      check("rst_dig", 32'(dig_sel), 32'd0);
      for (int i = 0; i < 50; i++) begin
         step();
         check("idle_count", 32'(count), 32'd0);
         check("idle_run", 32'(running), 32'd0);
         check("idle_tick", 32'(tick), 32'd0);
         check_display(SEG_0, SEG_0, "idle");
      end

      // control priority table
      for (int i = 0; i < 8; i++) begin
         pulse(tbl[i].rt, tbl[i].cl, tbl[i].ld, tbl[i].val);
         check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
         check($sformatf("tbl%0d_run", i), 32'(running), 32'(tbl[i].exp_run));
         check($sformatf("tbl%0d_tick", i), 32'(tick), 32'd0);
      end

      // 2: 25 ticks at one per 10 cycles
      pulse(1'b1, 1'b0, 1'b0, 16'h0);
      for (int i = 1; i <= 250; i++) begin
         step();
         check("run_tick", 32'(tick), 32'(i % 10 == 0));
         if (i % 10 == 0) check("run_count", 32'(count), 32'(i / 10));
      end
      check("run_25", 32'(count), 32'h0019);

      // 3: pause after 4 running cycles, resume, 6 more to the tick
      repeat (3) step();
      pulse(1'b1, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 20; i++) begin
         step();
         check("pause_tick", 32'(tick), 32'd0);
         check("pause_run", 32'(running), 32'd0);
      end
      pulse(1'b1, 1'b0, 1'b0, 16'h0);
      check("resume_run", 32'(running), 32'd1);
      for (int i = 1; i <= 6; i++) begin
         step();
         check("resume_tick", 32'(tick), 32'(i == 6));
      end
      check("resume_count", 32'(count), 32'h001A);

      // 4: wrap through 0xFFFF
      pulse(1'b0, 1'b0, 1'b1, 16'hFFFE);
      check("load_count", 32'(count), 32'hFFFE);
      check("load_tick", 32'(tick), 32'd0);
      for (int i = 1; i <= 20; i++) begin
         step();
         check("wrap_tick", 32'(tick), 32'(i == 10 || i == 20));
         check("wrap_wrap", 32'(wrap), 32'(i == 20));
         if (i == 10) check("wrap_ffff", 32'(count), 32'hFFFF);
         if (i == 20) check("wrap_zero", 32'(count), 32'h0000);
      end
      step();
      check("post_wrap_tick", 32'(tick), 32'd0);
      check("post_wrap_wrap", 32'(wrap), 32'd0);
      pulse(1'b1, 1'b0, 1'b0, 16'h0);

      // 5: display of latched byte, low then high selection
      disp_sel = 1'b0;
      pulse(1'b0, 1'b0, 1'b1, 16'h003A);
      sync_frame();
      check_frame(SEG_A, SEG_3, "disp_lo");
      disp_sel = 1'b1;
      pulse(1'b0, 1'b0, 1'b1, 16'hD700);
      sync_frame();
      check_frame(SEG_7, SEG_D, "disp_hi");

      // 6: clear+load+toggle on the would-be tick edge
      pulse(1'b1, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 9; i++) begin
         step();
         check("pre6_tick", 32'(tick), 32'd0);
      end
      pulse(1'b1, 1'b1, 1'b1, 16'h1234);
      check("t6_count", 32'(count), 32'd0);
      check("t6_run", 32'(running), 32'd0);
      check("t6_tick", 32'(tick), 32'd0);
      check("t6_wrap", 32'(wrap), 32'd0);
      pulse(1'b1, 1'b0, 1'b0, 16'h0);
      for (int i = 1; i <= 10; i++) begin
         step();
         check("t6_div_tick", 32'(tick), 32'(i == 10));
      end
      check("t6_div_count", 32'(count), 32'd1);

      // reset mid-period leaves no pending tick
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst2_run", 32'(running), 32'd0);
      for (int i = 0; i < 12; i++) begin
         step();
         check("rst2_tick", 32'(tick), 32'd0);
         check("rst2_count", 32'(count), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
